// File: rtl/ksa_pipelined_adder.sv
// Pipelined Kogge-Stone add/sub with a register every PIPE_EVERY prefix levels; latency 1 + ceil(LEVELS/PIPE_EVERY).
// The whole pipe advances together when the output slot is empty or being drained, otherwise every stage holds.
module ksa_pipelined_adder #(
   parameter int WIDTH      = 32,
   parameter int PIPE_EVERY = 1,
   parameter int TAG_W      = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic [TAG_W-1:0] out_tag
);

   localparam int LEVELS = $clog2(WIDTH);
   localparam int NSTG   = (LEVELS + PIPE_EVERY - 1) / PIPE_EVERY;

   logic             adv;
   logic [NSTG:0]    vld;
   logic [NSTG:0]    sb_c0;
   logic [NSTG:0]    sb_am;
   logic [NSTG:0]    sb_bm;
   logic [WIDTH-1:0] sb_p   [0:NSTG];
   logic [TAG_W-1:0] sb_tag [0:NSTG];
   logic [WIDTH-1:0] rg     [0:NSTG];
   logic [WIDTH-1:0] rp     [0:NSTG-1];
   logic [WIDTH-1:0] lg     [1:LEVELS];
   logic [WIDTH-1:0] lp     [1:LEVELS];
   logic [WIDTH-1:0] ng     [1:NSTG];
   logic [WIDTH-1:0] np     [1:NSTG];

   logic [WIDTH-1:0] bx;
   logic [WIDTH-1:0] p0;
   logic [WIDTH-1:0] g0;
   logic             c0;
   logic [WIDTH-1:0] carry;

   assign bx = in_sub ? ~in_b : in_b;
   assign c0 = in_sub | in_cin;
   assign p0 = in_a ^ bx;
   // Carry-in folded into bit 0 so the prefix tree yields true carries directly.
   assign g0 = (in_a & bx) | {{(WIDTH-1){1'b0}}, p0[0] & c0};

   for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
      localparam int D = 1 << k;
      localparam logic [WIDTH-1:0] LOWMASK = ~({WIDTH{1'b1}} << D);
      logic [WIDTH-1:0] gin;
      logic [WIDTH-1:0] pin;
      if (k % PIPE_EVERY == 0) begin : g_from_reg
         assign gin = rg[k / PIPE_EVERY];
         assign pin = rp[k / PIPE_EVERY];
      end else begin : g_from_lvl
         assign gin = lg[k];
         assign pin = lp[k];
      end
      // Shifted-in zeros leave bits below D untouched; LOWMASK does the same for P.
      assign lg[k+1] = gin | (pin & (gin << D));
      assign lp[k+1] = pin & ((pin << D) | LOWMASK);
   end

   for (genvar s = 1; s <= NSTG; s++) begin : g_stg
      localparam int LI = (s * PIPE_EVERY < LEVELS) ? s * PIPE_EVERY : LEVELS;
      assign ng[s] = lg[LI];
      assign np[s] = lp[LI];
   end

   assign adv       = ~vld[NSTG] | out_ready;
   assign in_ready  = adv;
   assign out_valid = vld[NSTG];

   always_ff @(posedge clk) begin
      if (rst) begin
         vld   <= '0;
         sb_c0 <= '0;
         sb_am <= '0;
         sb_bm <= '0;
         for (int s = 0; s <= NSTG; s++) begin
            sb_p[s]   <= '0;
            sb_tag[s] <= '0;
            rg[s]     <= '0;
         end
         for (int s = 0; s < NSTG; s++) begin
            rp[s] <= '0;
         end
      end else if (adv) begin
         vld   <= {vld[NSTG-1:0], in_valid};
         sb_c0 <= {sb_c0[NSTG-1:0], c0};
         sb_am <= {sb_am[NSTG-1:0], in_a[WIDTH-1]};
         sb_bm <= {sb_bm[NSTG-1:0], bx[WIDTH-1]};
         sb_p[0]   <= p0;
         sb_tag[0] <= in_tag;
         rg[0]     <= g0;
         rp[0]     <= p0;
         for (int s = 1; s <= NSTG; s++) begin
            sb_p[s]   <= sb_p[s-1];
            sb_tag[s] <= sb_tag[s-1];
            rg[s]     <= ng[s];
         end
         for (int s = 1; s < NSTG; s++) begin
            rp[s] <= np[s];
         end
      end
   end

   assign carry    = {rg[NSTG][WIDTH-2:0], sb_c0[NSTG]};
   assign out_sum  = sb_p[NSTG] ^ carry;
   assign out_cout = rg[NSTG][WIDTH-1];
   assign out_ovf  = (sb_am[NSTG] == sb_bm[NSTG]) & (out_sum[WIDTH-1] != sb_am[NSTG]);
   assign out_tag  = sb_tag[NSTG];

endmodule
